// File: rtl/button_conditioner_if.sv
// Button bundle between the board push-buttons, the conditioner and the game core.
//   btn_raw     : raw asynchronous button levels, bit order {C, D, R, L, U}
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse on an accepted rising edge
//   btn_release : one-cycle pulse on an accepted falling edge
//   btn_repeat  : press pulse followed by auto-repeat pulses while held
// master = conditioner side, slave = consumer side.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 5
) ();
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-button two-flop synchroniser, debounce counter,
// registered press/release pulses and an auto-repeat FSM (IDLE/DELAY/REPEAT).
//   clk     : board clock, the only clock
//   reset_n : asynchronous active-low reset
//   btn     : button bundle (master modport), see button_conditioner_if
// Channels are identical and independent.
module button_conditioner #(
  parameter int unsigned N_BTN               = 5,
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 10_000_000
) (
  input logic                 clk,
  input logic                 reset_n,
  button_conditioner_if.master btn
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_e;

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, press_q, release_q, repeat_q;
  logic [DB_W-1:0]  db_cnt_q [N_BTN];

  logic [N_BTN-1:0] accept, rise, fall;

  rep_state_e       state_q [N_BTN];
  rep_state_e       state_d [N_BTN];
  logic [REP_W-1:0] rcnt_q  [N_BTN];
  logic [REP_W-1:0] rcnt_d  [N_BTN];
  logic [N_BTN-1:0] repeat_d;

  // A change is accepted on the cycle the counter would reach DEBOUNCE_CYCLES,
  // so the outputs register together with the new level.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      accept[i] = (s2_q[i] != level_q[i]) && (db_cnt_q[i] == DB_LAST);
    end
    rise = accept & s2_q;
    fall = accept & ~s2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= btn.btn_raw;
      s2_q      <= s1_q;
      level_q   <= level_q ^ accept;
      press_q   <= rise;
      release_q <= fall;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if ((s2_q[i] == level_q[i]) || accept[i]) begin
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_ONE;
        end
      end
    end
  end

  // Repeat counter holds the number of cycles elapsed since the last repeat
  // pulse (1 in the cycle after the pulse); a pulse is due when it equals the
  // period. A falling edge wins over a due pulse.
  always_comb begin
    repeat_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            repeat_d[i] = 1'b1;
            rcnt_d[i]   = REP_ONE;
            state_d[i]  = DELAY;
          end
        end
        DELAY: begin
          if (fall[i]) begin
            rcnt_d[i]  = '0;
            state_d[i] = IDLE;
          end else if (rcnt_q[i] == DELAY_LAST) begin
            repeat_d[i] = 1'b1;
            rcnt_d[i]   = REP_ONE;
            state_d[i]  = REPEAT;
          end else if (rcnt_q[i] != '1) begin
            rcnt_d[i] = rcnt_q[i] + REP_ONE;
          end
        end
        REPEAT: begin
          if (fall[i]) begin
            rcnt_d[i]  = '0;
            state_d[i] = IDLE;
          end else if (rcnt_q[i] == RATE_LAST) begin
            repeat_d[i] = 1'b1;
            rcnt_d[i]   = REP_ONE;
          end else if (rcnt_q[i] != '1) begin
            rcnt_d[i] = rcnt_q[i] + REP_ONE;
          end
        end
        default: begin
          rcnt_d[i]  = '0;
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repeat_q <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      repeat_q <= repeat_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.
// Cycle c of a scenario: btn_raw is the value driven before rising edge c,
// expectations are the outputs sampled after edge c.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(5)) btn ();

  button_conditioner #(
    .N_BTN(5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn(btn)
  );

  typedef struct {
    int         scn;
    int         c;
    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] rep;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int scn, input int c,
                       input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s scn=%0d c=%0d got=%b want=%b", name, scn, c, got, exp);
    end
  endtask

  task automatic add_vec(input int scn, input int c, input logic [4:0] raw,
                         input logic [4:0] level, input logic [4:0] press,
                         input logic [4:0] rel, input logic [4:0] rep);
    vec_t v;
    v.scn = scn; v.c = c; v.raw = raw;
    v.level = level; v.press = press; v.rel = rel; v.rep = rep;
    vecs.push_back(v);
  endtask

  task automatic fill_table();
    logic [4:0] r, l, p, rl, rp;
    // 1: clean press/hold/release on bit 4, raw high c=1..30
    for (int c = 1; c <= 40; c++) begin
      r = '0; l = '0; p = '0; rl = '0; rp = '0;
      r[4]  = (c <= 30);
      l[4]  = (c >= 6) && (c <= 35);
      p[4]  = (c == 6);
      rl[4] = (c == 36);
      rp[4] = (c == 6) || (c == 16) || (c == 19) || (c == 22) ||
              (c == 25) || (c == 28) || (c == 31) || (c == 34);
      add_vec(1, c, r, l, p, rl, rp);
    end
    // 2: bounce on bit 0 (1,1,0,0,1,1,0,0), then held from c=9 to c=20
    for (int c = 1; c <= 30; c++) begin
      r = '0; l = '0; p = '0; rl = '0; rp = '0;
      r[0]  = (c <= 2) || (c == 5) || (c == 6) || ((c >= 9) && (c <= 20));
      l[0]  = (c >= 14) && (c <= 25);
      p[0]  = (c == 14);
      rl[0] = (c == 26);
      rp[0] = (c == 14) || (c == 24);
      add_vec(2, c, r, l, p, rl, rp);
    end
    // 3: bit 3 released 5 cycles after press (in DELAY), then re-pressed
    //    and held 30 cycles after its press at c=20
    for (int c = 1; c <= 55; c++) begin
      r = '0; l = '0; p = '0; rl = '0; rp = '0;
      r[3]  = (c <= 5) || ((c >= 15) && (c <= 44));
      l[3]  = ((c >= 6) && (c <= 10)) || ((c >= 20) && (c <= 49));
      p[3]  = (c == 6) || (c == 20);
      rl[3] = (c == 11) || (c == 50);
      rp[3] = (c == 6) || (c == 20) || (c == 30) || (c == 33) || (c == 36) ||
              (c == 39) || (c == 42) || (c == 45) || (c == 48);
      add_vec(3, c, r, l, p, rl, rp);
    end
    // 4: bits 0 and 2 together; bit 2 dropped early, bit 0 keeps repeating
    for (int c = 1; c <= 40; c++) begin
      r = '0; l = '0; p = '0; rl = '0; rp = '0;
      r[0]  = (c <= 29);
      r[2]  = (c <= 7);
      l[0]  = (c >= 6) && (c <= 34);
      l[2]  = (c >= 6) && (c <= 12);
      p[0]  = (c == 6);
      p[2]  = (c == 6);
      rl[0] = (c == 35);
      rl[2] = (c == 13);
      rp[0] = (c == 6) || (c == 16) || (c == 19) || (c == 22) ||
              (c == 25) || (c == 28) || (c == 31) || (c == 34);
      rp[2] = (c == 6);
      add_vec(4, c, r, l, p, rl, rp);
    end
  endtask

  initial begin
    logic [4:0] exp_p, exp_l;
    btn.btn_raw = '0;
    fill_table();

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_level",   0, 0, btn.btn_level,   5'b00000);
    check("reset_press",   0, 0, btn.btn_press,   5'b00000);
    check("reset_release", 0, 0, btn.btn_release, 5'b00000);
    check("reset_repeat",  0, 0, btn.btn_repeat,  5'b00000);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      btn.btn_raw = vecs[k].raw;
      @(negedge clk);
      check("level",   vecs[k].scn, vecs[k].c, btn.btn_level,   vecs[k].level);
      check("press",   vecs[k].scn, vecs[k].c, btn.btn_press,   vecs[k].press);
      check("release", vecs[k].scn, vecs[k].c, btn.btn_release, vecs[k].rel);
      check("repeat",  vecs[k].scn, vecs[k].c, btn.btn_repeat,  vecs[k].rep);
    end

    // Reset in the REPEAT phase of bit 1 while raw stays high
    btn.btn_raw = 5'b00010;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    check("pre_reset_level", 5, 20, btn.btn_level, 5'b00010);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_level",   5, 0, btn.btn_level,   5'b00000);
    check("async_press",   5, 0, btn.btn_press,   5'b00000);
    check("async_release", 5, 0, btn.btn_release, 5'b00000);
    check("async_repeat",  5, 0, btn.btn_repeat,  5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_p = (c == 6) ? 5'b00010 : 5'b00000;
      exp_l = (c >= 6) ? 5'b00010 : 5'b00000;
      check("post_reset_press",  5, c, btn.btn_press,  exp_p);
      check("post_reset_level",  5, c, btn.btn_level,  exp_l);
      check("post_reset_repeat", 5, c, btn.btn_repeat, exp_p);
    end
    btn.btn_raw = '0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    @(negedge clk);
    check("post_reset_release", 5, 14, btn.btn_release, 5'b00010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage between the board push-buttons and the pong game core. Synchronises the five raw buttons (btnU, btnL, btnR, btnD, btnC) to `clk`, debounces each one and produces a clean level, one-cycle press and release pulses, and an auto-repeat pulse stream. Its outputs feed the game core: the launch edge, paddle levels, and max-score up/down steps. These replace the raw-level sampling and the separate 25 Hz divider.

## Interface
- `N_BTN`, 5: number of buttons; bit order {btnC, btnD, btnR, btnL, btnU} = bits 4..0
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a change (10 ms at 100 MHz); legal range ≥1
- `REPEAT_DELAY_CYCLES`, 50_000_000: cycles from press pulse to first auto-repeat pulse; legal range ≥1
- `REPEAT_RATE_CYCLES`, 10_000_000: cycles between subsequent auto-repeat pulses; legal range ≥1

Ports:
- `clk`  in  1  100 MHz board clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `btn_raw`  in  N_BTN  raw, asynchronous button inputs
- `btn_level`  out  N_BTN  debounced level, registered
- `btn_press`  out  N_BTN  one-cycle pulse in the first cycle `btn_level` reads 1
- `btn_release`  out  N_BTN  one-cycle pulse in the first cycle `btn_level` reads 0
- `btn_repeat`  out  N_BTN  one-cycle pulses: coincident with `btn_press`, then auto-repeat while held

## Operation
Each button has an identical, independent channel with no cross-coupling.
- Synchroniser: two flops, s1 then s2, both reset to 0.
- Debounce:
  - The counter increments each cycle that s2 ≠ `btn_level`.
  - It clears to 0 on any cycle s2 = `btn_level`, so a bounce restarts the count.
  - When the counter would reach `DEBOUNCE_CYCLES`, `btn_level` toggles and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- Press and release:
  - `btn_press` and `btn_release` are registered alongside `btn_level`.
  - Exactly one pulse is produced per accepted edge.
- Repeat FSM per button, states IDLE, DELAY, REPEAT:
  - IDLE: on the accepted rising edge, assert `btn_repeat` with `btn_press`, load the repeat counter, and go to DELAY.
  - DELAY: after `REPEAT_DELAY_CYCLES` cycles counted from the press cycle, pulse `btn_repeat`, reload the counter, and go to REPEAT.
  - REPEAT: pulse `btn_repeat` every `REPEAT_RATE_CYCLES` cycles.
  - In DELAY or REPEAT, an accepted falling edge returns the FSM to IDLE. No `btn_repeat` is asserted in the release cycle or afterwards.
  - Repeat counter width is clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1).
  - The counter saturates, never wraps.
- Reset (async assert, at any time including mid-debounce or mid-repeat):
  - All flops, counters, and outputs go to 0; the FSM goes to IDLE.
  - If a button is held through reset release, it is treated as a new press: one `btn_press` after the normal debounce latency.

## Timing
- Reset values: `btn_level`, `btn_press`, `btn_release`, `btn_repeat` all 0.
- Latency, rising edge: `btn_raw` goes high before edge k and stays stable. s2 reads 1 after edge k+1. `btn_level`, `btn_press` and `btn_repeat` go high after edge k+1+DEBOUNCE_CYCLES.
- Latency, falling edge: the same latency applies to `btn_release`.
- Pulse width: all pulse outputs are exactly one `clk` cycle.
- Auto-repeat: a press pulse in cycle P gives repeat pulses in cycles P+D, P+D+R, P+D+2R, … (D = `REPEAT_DELAY_CYCLES`, R = `REPEAT_RATE_CYCLES`).
- Simultaneous events: buttons pressed or released in the same cycle produce their pulses in the same cycle, each independently.
- Downstream contract:
  - The core uses `btn_press[4]` for launch and `btn_level[0]/[3]/[1]/[2]` for the paddles.
  - It uses `btn_repeat[0]/[3]` for score up/down in the set state.

## Test plan
All directed tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.
- **Clean press/release:** raise `btn_raw[4]` at cycle 0 and hold for 30 cycles, then drop it.
  - `btn_level[4]`=1 from cycle 6.
  - `btn_press[4]` and `btn_repeat[4]` are high in cycle 6 only among press pulses.
  - `btn_release[4]` pulses once 6 cycles after the drop.
- **Bounce rejection:** toggle `btn_raw[0]` 1,0,1,0 with 2-cycle high/low periods, then hold 1.
  - No output activity during the bounce.
  - `btn_press[0]` fires exactly once, 6 cycles after the final rise.
- **Auto-repeat:** hold `btn_raw[3]` for 30 cycles after `btn_press` (cycle P).
  - `btn_repeat[3]` is high at P, P+10, P+13, P+16, …, P+28.
  - No `btn_repeat[3]` pulse after the release cycle.
- **Release during DELAY:** release 5 cycles after press.
  - Only one `btn_repeat` pulse (at P).
  - The FSM is back in IDLE, and the next press restarts the delay.
- **Simultaneous buttons:** raise bits 0 and 2 in the same cycle.
  - Both `btn_press` bits pulse in the same cycle.
  - Bit 2 released early does not disturb bit 0's repeat sequence.
- **Reset mid-operation:** assert `reset_n`=0 in the middle of the REPEAT phase while `btn_raw[1]` stays high.
  - All outputs read 0 immediately, asynchronously.
  - After release, `btn_press[1]` pulses 6 cycles later.
